// File: rtl/idli_pkg.sv
// ----------------------------------------------------------------------------
// idli_pkg
//   Shared definitions for the idli core slice-serial datapath and its
//   peripherals. The core moves one SLICE_W-bit slice per cycle, so one
//   datum takes NUM_SLICES cycles, which is also the length of an
//   instruction window.
//
//   Contents:
//     NUM_IO_PINS  default pin count for the GPIO controller
//     SLICE_W      bits per data slice
//     NUM_SLICES   slices per datum / cycles per op
//     CTR_W        width of the core slice counter (at least 1)
//     DATA_W       full datum width
//     slice_t      one data slice
//     data_t       one full datum
//     pin_op_t     GPIO controller operation code (3 bits)
//     is_rd_op     true for ops that return data on o_slice
// ----------------------------------------------------------------------------
package idli_pkg;

    localparam int unsigned NUM_IO_PINS = 4;
    localparam int unsigned SLICE_W     = 4;
    localparam int unsigned NUM_SLICES  = 4;
    localparam int unsigned CTR_W       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int unsigned DATA_W      = SLICE_W * NUM_SLICES;

    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_SET   = 3'd3,
        OP_CLR   = 3'd4,
        OP_EDGE  = 3'd5
    } pin_op_t;

    // READ and EDGE are the only ops that drive o_slice.
    function automatic logic is_rd_op(input pin_op_t op);
        return (op == OP_READ) || (op == OP_EDGE);
    endfunction

endpackage

// File: rtl/idli_sync_m.sv
// ----------------------------------------------------------------------------
// idli_sync_m
//   One-bit multi-flop synchroniser for an asynchronous input. The input is
//   visible on o_q after STAGES rising clock edges.
//
//   Parameters:
//     STAGES   number of flops in the chain (>= 2)
//   Ports:
//     i_clk    clock
//     i_rst    asynchronous active-high reset, clears the chain
//     i_d      asynchronous input bit
//     o_q      synchronised output bit
// ----------------------------------------------------------------------------
module idli_sync_m #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain[STAGES-1];

endmodule

// File: rtl/idli_pin_ctrl_m.sv
// ----------------------------------------------------------------------------
// idli_pin_ctrl_m
//   General-purpose I/O pin controller. Input pins are synchronised and
//   watched for rising edges, which set sticky per-pin flags. Output pins are
//   registered. The core talks to the block with slice-serial ops, one
//   SLICE_W-bit slice per cycle across a NUM_SLICES-cycle window that starts
//   when i_ctr is 0.
//
//   Ops:
//     NOP    nothing
//     READ   return synchronised pin levels, LSB slice first
//     EDGE   return sticky edge flags; flags read as 1 clear at the end
//     WRITE  o_pins <= datum
//     SET    o_pins <= o_pins | datum
//     CLR    o_pins <= o_pins & ~datum
//
//   Parameters:
//     NUM_PINS     number of input pins and output pins
//     SLICE_W      bits per slice
//     NUM_SLICES   slices per datum / cycles per op
//     SYNC_STAGES  synchroniser flops per input pin (>= 2)
//   Ports:
//     i_clk     clock
//     i_rst     asynchronous active-high reset
//     i_pins    asynchronous input pins
//     o_pins    registered output pins
//     i_ctr     core slice counter, 0..NUM_SLICES-1
//     i_op_vld  op start, honoured only when i_ctr == 0
//     i_op      operation code
//     i_slice   operand slice for the current i_ctr
//     o_slice   result slice for the current i_ctr (combinational)
//     o_edge    OR of all sticky edge flags
// ----------------------------------------------------------------------------
module idli_pin_ctrl_m #(
    parameter  int unsigned NUM_PINS    = idli_pkg::NUM_IO_PINS,
    parameter  int unsigned SLICE_W     = idli_pkg::SLICE_W,
    parameter  int unsigned NUM_SLICES  = idli_pkg::NUM_SLICES,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned CTR_W       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_PINS-1:0] i_pins,
    output logic [NUM_PINS-1:0] o_pins,
    input  logic [CTR_W-1:0]    i_ctr,
    input  logic                i_op_vld,
    input  idli_pkg::pin_op_t   i_op,
    input  logic [SLICE_W-1:0]  i_slice,
    output logic [SLICE_W-1:0]  o_slice,
    output logic                o_edge
);

    import idli_pkg::*;

    localparam int unsigned      DATA_W    = SLICE_W * NUM_SLICES;
    localparam logic [CTR_W-1:0] LAST_STEP = CTR_W'(NUM_SLICES - 1);

    // Input side
    logic [NUM_PINS-1:0] sync;
    logic [NUM_PINS-1:0] sync_prev;
    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] flags;

    // Op sequencing
    pin_op_t             op_q;
    pin_op_t             cur_op;
    logic                busy_q;
    logic                start;
    logic                active;
    logic                last;
    logic [CTR_W-1:0]    step_q;
    logic [CTR_W-1:0]    cur_step;

    // Read path
    logic [NUM_PINS-1:0] snap;
    logic [NUM_PINS-1:0] rd_src;
    logic [NUM_PINS-1:0] rd_val;
    logic [NUM_PINS-1:0] clr_mask;

    // Write path
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_nxt;
    logic [NUM_PINS-1:0] pins_d;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_sync
        idli_sync_m #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (i_pins[p]),
            .o_q   (sync[p])
        );
    end

    always_comb begin
        // A window is tracked by its own step counter once started, so the op
        // finishes even if the core counter does something unexpected, and a
        // fresh start is not accepted while one is still in flight.
        start    = i_op_vld && (i_ctr == '0) && !busy_q;
        active   = start || busy_q;
        cur_op   = OP_NOP;
        if (start) begin
            cur_op = i_op;
        end else if (busy_q) begin
            cur_op = op_q;
        end
        cur_step = start ? '0 : step_q;
        last     = active && (cur_step == LAST_STEP);

        rise     = sync & ~sync_prev;

        // Slice 0 bypasses the snapshot so the first slice is returned in the
        // same cycle the op is issued; later slices come from the snapshot.
        rd_src   = (cur_op == OP_EDGE) ? flags : sync;
        rd_val   = start ? rd_src : snap;

        o_slice  = '0;
        if (is_rd_op(cur_op)) begin
            o_slice = SLICE_W'(DATA_W'(rd_val) >> (32'(i_ctr) * SLICE_W));
        end

        // Operand arrives LSB slice first: shift right, insert at the top.
        // After NUM_SLICES shifts slice 0 sits at the bottom.
        acc_nxt  = (acc_q >> SLICE_W) | (DATA_W'(i_slice) << (DATA_W - SLICE_W));
        pins_d   = NUM_PINS'(acc_nxt);

        // Only flags that were returned as 1 are cleared.
        clr_mask = (last && (cur_op == OP_EDGE)) ? rd_val : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_prev <= '0;
            flags     <= '0;
            snap      <= '0;
            acc_q     <= '0;
            op_q      <= OP_NOP;
            busy_q    <= 1'b0;
            step_q    <= '0;
            o_pins    <= '0;
        end else begin
            sync_prev <= sync;
            // New rising edges are ORed in after the clear, so an edge landing
            // in the clear cycle survives.
            flags     <= (flags & ~clr_mask) | rise;

            if (start) begin
                snap <= rd_src;
            end

            if (active) begin
                acc_q <= acc_nxt;
                if (last) begin
                    busy_q <= 1'b0;
                    op_q   <= OP_NOP;
                    step_q <= '0;
                end else begin
                    busy_q <= 1'b1;
                    op_q   <= cur_op;
                    step_q <= cur_step + CTR_W'(1);
                end
            end

            if (last) begin
                case (cur_op)
                    OP_WRITE: o_pins <= pins_d;
                    OP_SET:   o_pins <= o_pins | pins_d;
                    OP_CLR:   o_pins <= o_pins & ~pins_d;
                    default:  ;
                endcase
            end
        end
    end

    assign o_edge = |flags;

endmodule

// File: tb/tb_idli_pin_ctrl_m.sv
module tb_idli_pin_ctrl_m;
    import idli_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] ctr;
    logic       op_vld;
    pin_op_t    op_in;
    logic [3:0] slc;
    logic [3:0] p4;
    logic [5:0] p6;
    logic [3:0] o_pins4;
    logic [5:0] o_pins6;
    logic [3:0] o_slice4;
    logic [3:0] o_slice6;
    logic       o_edge4;
    logic       o_edge6;

    int n_vec = 0;
    int n_err = 0;

    idli_pin_ctrl_m u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_pins(p4), .o_pins(o_pins4),
        .i_ctr(ctr), .i_op_vld(op_vld), .i_op(op_in), .i_slice(slc),
        .o_slice(o_slice4), .o_edge(o_edge4)
    );

    idli_pin_ctrl_m #(.NUM_PINS(6)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_pins(p6), .o_pins(o_pins6),
        .i_ctr(ctr), .i_op_vld(op_vld), .i_op(op_in), .i_slice(slc),
        .o_slice(o_slice6), .o_edge(o_edge6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // samp[k][a]: pin value sampled a+1 clock edges ago (a=0 most recent)
    logic [15:0] m_samp [2][3];
    logic [15:0] m_flags [2];
    logic [15:0] m_pins  [2];
    logic [15:0] m_snap  [2];
    pin_op_t     m_op;
    bit          m_busy;
    int          m_step;
    logic [15:0] m_data;

    // per-slot observations of the last window
    logic [3:0] obs_slice4 [4];
    logic [3:0] obs_slice6 [4];
    logic [5:0] obs_pins4  [4];
    logic       obs_edge4  [4];

    bit         sched_en = 1'b0;
    logic [5:0] sch4 [4];
    logic [5:0] sch6 [4];

    function automatic logic [15:0] pmask(input int k);
        return (k == 0) ? 16'h000F : 16'h003F;
    endfunction

    function automatic logic [15:0] pins_now(input int k);
        return (k == 0) ? {12'd0, p4} : {10'd0, p6};
    endfunction

    function automatic bit m_start();
        return op_vld && (ctr == 2'd0) && !m_busy;
    endfunction

    function automatic pin_op_t m_cur_op();
        if (m_start()) return op_in;
        if (m_busy) return m_op;
        return OP_NOP;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 3; a++) m_samp[k][a] = '0;
            m_flags[k] = '0;
            m_pins[k]  = '0;
            m_snap[k]  = '0;
        end
        m_op = OP_NOP; m_busy = 0; m_step = 0; m_data = '0;
    endtask

    task automatic model_update();
        bit st;
        bit act;
        bit lst;
        int idx;
        pin_op_t op;
        logic [15:0] rise [2];
        logic [15:0] clr;
        st  = m_start();
        op  = m_cur_op();
        act = st || m_busy;
        idx = st ? 0 : m_step;
        for (int k = 0; k < 2; k++) rise[k] = m_samp[k][1] & ~m_samp[k][2];
        if (st) begin
            m_data = '0;
            for (int k = 0; k < 2; k++)
                m_snap[k] = (op == OP_EDGE) ? m_flags[k] : m_samp[k][1];
        end
        if (act) m_data = m_data | (16'(slc) << (4 * idx));
        lst = act && (idx == 3);
        for (int k = 0; k < 2; k++) begin
            clr = (lst && op == OP_EDGE) ? m_snap[k] : 16'd0;
            m_flags[k] = (m_flags[k] & ~clr) | rise[k];
            if (lst) begin
                case (op)
                    OP_WRITE: m_pins[k] = m_data & pmask(k);
                    OP_SET:   m_pins[k] = (m_pins[k] | m_data) & pmask(k);
                    OP_CLR:   m_pins[k] = m_pins[k] & ~m_data & pmask(k);
                    default:  ;
                endcase
            end
        end
        if (act) begin
            if (lst) begin m_busy = 0; m_op = OP_NOP; m_step = 0; end
            else     begin m_busy = 1; m_op = op; m_step = idx + 1; end
        end
        for (int k = 0; k < 2; k++) begin
            m_samp[k][2] = m_samp[k][1];
            m_samp[k][1] = m_samp[k][0];
            m_samp[k][0] = pins_now(k);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        pin_op_t op;
        logic [15:0] val;
        logic [15:0] exp_sl [2];
        op = m_cur_op();
        for (int k = 0; k < 2; k++) begin
            exp_sl[k] = '0;
            if (op == OP_READ || op == OP_EDGE) begin
                if (m_start()) val = (op == OP_READ) ? m_samp[k][1] : m_flags[k];
                else           val = m_snap[k];
                exp_sl[k] = (val >> (4 * ctr)) & 16'h000F;
            end
        end
        chk("slice4", 16'(o_slice4), exp_sl[0]);
        chk("slice6", 16'(o_slice6), exp_sl[1]);
        chk("pins4",  16'(o_pins4),  m_pins[0]);
        chk("pins6",  16'(o_pins6),  m_pins[1]);
        chk("edge4",  16'(o_edge4),  16'(m_flags[0] != 0));
        chk("edge6",  16'(o_edge6),  16'(m_flags[1] != 0));
        obs_slice4[ctr] = o_slice4;
        obs_slice6[ctr] = o_slice6;
        obs_pins4[ctr]  = 6'(o_pins4);
        obs_edge4[ctr]  = o_edge4;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic window(input pin_op_t op, input logic [15:0] d, input int vld_at);
        for (int s = 0; s < 4; s++) begin
            ctr    = 2'(s);
            op_vld = (s == vld_at);
            op_in  = op;
            slc    = d[4*s +: 4];
            if (sched_en) begin
                p4 = sch4[s][3:0];
                p6 = sch6[s];
            end
            tick();
        end
        op_vld = 1'b0;
        op_in  = OP_NOP;
        slc    = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; ctr = '0; op_vld = 1'b0; op_in = OP_NOP; slc = '0;
        p4 = '0; p6 = '0;
        #1 rst = 1'b1;
        model_reset();
        tick();
        chk("rst_pins4", 16'(o_pins4), 16'h0);
        chk("rst_slice4", 16'(o_slice4), 16'h0);
        chk("rst_edge4", 16'(o_edge4), 16'h0);
        tick();
        rst = 1'b0;

        // Reset in the middle of a WRITE of 0x000F
        ctr = 2'd0; op_vld = 1'b1; op_in = OP_WRITE; slc = 4'hF;
        tick();
        ctr = 2'd1; op_vld = 1'b0; slc = 4'h0;
        tick();
        ctr = 2'd2;
        rst = 1'b1;
        #1 model_reset();
        chk("midrst_pins", 16'(o_pins4), 16'h0);
        tick();
        ctr = 2'd3;
        tick();
        rst = 1'b0; op_in = OP_NOP;
        window(OP_NOP, 16'h0, 4);
        chk("midrst_pins_after", 16'(o_pins4), 16'h0);
        chk("midrst_edge_after", 16'(o_edge4), 16'h0);

        // READ of pins held at 1010
        p4 = 4'b1010; p6 = 6'b001010;
        window(OP_NOP, 16'h0, 4);
        window(OP_READ, 16'h0, 0);
        chk("read_s0", 16'(obs_slice4[0]), 16'hA);
        chk("read_s1", 16'(obs_slice4[1]), 16'h0);
        chk("read_s2", 16'(obs_slice4[2]), 16'h0);
        chk("read_s3", 16'(obs_slice4[3]), 16'h0);

        // WRITE / SET / CLR, each landing one cycle after its window
        window(OP_WRITE, 16'h0005, 0);
        chk("write_pre", 16'(obs_pins4[3]), 16'h0);
        chk("write", 16'(o_pins4), 16'h5);
        window(OP_SET, 16'h0008, 0);
        chk("set_pre", 16'(obs_pins4[3]), 16'h5);
        chk("set", 16'(o_pins4), 16'hD);
        window(OP_CLR, 16'h0001, 0);
        chk("clr_pre", 16'(obs_pins4[3]), 16'hD);
        chk("clr", 16'(o_pins4), 16'hC);
        chk("clr6", 16'(o_pins6), 16'hC);

        // Clear leftover flags, then pulse pin 2
        p4 = '0; p6 = '0;
        window(OP_NOP, 16'h0, 4);
        window(OP_EDGE, 16'h0, 0);
        chk("edge_cleared", 16'(o_edge4), 16'h0);
        sched_en = 1'b1;
        sch4[0] = 6'h04; sch4[1] = 6'h00; sch4[2] = 6'h00; sch4[3] = 6'h00;
        sch6[0] = 6'h04; sch6[1] = 6'h00; sch6[2] = 6'h00; sch6[3] = 6'h00;
        window(OP_NOP, 16'h0, 4);
        sched_en = 1'b0;
        window(OP_NOP, 16'h0, 4);
        chk("edge_set", 16'(o_edge4), 16'h1);
        // EDGE read; pin 1 rises so its sync edge hits the clear cycle
        sched_en = 1'b1;
        sch4[0] = 6'h00; sch4[1] = 6'h02; sch4[2] = 6'h02; sch4[3] = 6'h02;
        sch6[0] = 6'h00; sch6[1] = 6'h00; sch6[2] = 6'h00; sch6[3] = 6'h00;
        window(OP_EDGE, 16'h0, 0);
        sched_en = 1'b0;
        chk("edge_s0", 16'(obs_slice4[0]), 16'h4);
        chk("edge6_s0", 16'(obs_slice6[0]), 16'h4);
        chk("edge_last_cycle", 16'(obs_edge4[3]), 16'h1);
        chk("edge_kept", 16'(o_edge4), 16'h1);
        chk("edge6_fell", 16'(o_edge6), 16'h0);
        window(OP_EDGE, 16'h0, 0);
        chk("edge2_s0", 16'(obs_slice4[0]), 16'h2);
        chk("edge2_fell", 16'(o_edge4), 16'h0);

        // Start strobe off the window boundary is ignored
        window(OP_WRITE, 16'h000F, 1);
        chk("late_vld_pins", 16'(o_pins4), 16'hC);
        chk("late_vld_slice", 16'(obs_slice4[1]), 16'h0);

        // Operand bits beyond the pin count are dropped; pad reads as 0
        window(OP_WRITE, 16'hFFFF, 0);
        chk("wide_pins6", 16'(o_pins6), 16'h3F);
        chk("wide_pins4", 16'(o_pins4), 16'hF);
        p4 = 4'hF; p6 = 6'h3F;
        window(OP_NOP, 16'h0, 4);
        window(OP_READ, 16'h0, 0);
        chk("read6_s0", 16'(obs_slice6[0]), 16'hF);
        chk("read6_s1", 16'(obs_slice6[1]), 16'h3);
        chk("read6_s2", 16'(obs_slice6[2]), 16'h0);
        chk("read6_s3", 16'(obs_slice6[3]), 16'h0);
        chk("read4_s1", 16'(obs_slice4[1]), 16'h0);

        // Randomised windows against the model
        sched_en = 1'b1;
        for (int w = 0; w < 80; w++) begin
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 2) == 0) begin
                    sch4[s] = 6'($urandom_range(0, 15));
                    sch6[s] = 6'($urandom_range(0, 63));
                end else if (s > 0) begin
                    sch4[s] = sch4[s-1];
                    sch6[s] = sch6[s-1];
                end
            end
            window(pin_op_t'($urandom_range(0, 5)), 16'($urandom),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        sched_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
